// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: counting modes,
// counter direction and the per-channel bus slice helper.
package pwm_pkg;

   localparam logic PWM_MODE_EDGE   = 1'b0;
   localparam logic PWM_MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // LSB position of channel ch inside a flattened CHANNELS*width bus
   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
      return ch * width;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter: edge/center counting, boundary detect, shadowed
// period/mode and the armed-update (pending) logic.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_mode,
   input  logic [WIDTH-1:0] pwm_period,
   input  logic             pwm_update,
   output logic [WIDTH-1:0] count,
   output logic             idle_c,
   output logic             load_c,
   output logic             done,
   output logic             pending
);

   logic [WIDTH-1:0] period_q;
   logic [WIDTH-1:0] count_n;
   logic             mode_q;
   dir_t             dir_q;
   dir_t             dir_n;
   logic             boundary_c;
   logic             pending_n;

   always_ff @(posedge clock) begin
      if (!reset) begin
         count    <= '0;
         dir_q    <= DIR_UP;
         period_q <= '0;
         mode_q   <= PWM_MODE_EDGE;
         pending  <= 1'b0;
         done     <= 1'b0;
      end else begin
         count   <= count_n;
         dir_q   <= dir_n;
         pending <= pending_n;
         done    <= boundary_c & ~idle_c;
         if (load_c) begin
            period_q <= pwm_period;
            mode_q   <= pwm_mode;
         end
      end
   end

   // Every boundary (and every idle cycle) restarts the period at 0 counting up
   always_comb begin
      idle_c     = (period_q == '0) || !enable;
      boundary_c = 1'b1;
      count_n    = '0;
      dir_n      = DIR_UP;
      if (!idle_c) begin
         if (mode_q == PWM_MODE_CENTER) begin
            boundary_c = ((dir_q == DIR_DOWN) && (count == WIDTH'(1))) ||
                         ((period_q == WIDTH'(1)) && (count == period_q));
         end else begin
            boundary_c = (count == period_q - WIDTH'(1));
         end
         if (!boundary_c) begin
            if (mode_q == PWM_MODE_EDGE) begin
               count_n = count + WIDTH'(1);
            end else if (dir_q == DIR_DOWN) begin
               count_n = count - WIDTH'(1);
               dir_n   = DIR_DOWN;
            end else if (count == period_q) begin
               count_n = period_q - WIDTH'(1);
               dir_n   = DIR_DOWN;
            end else begin
               count_n = count + WIDTH'(1);
            end
         end
      end
      load_c    = boundary_c && (pending || pwm_update);
      pending_n = (pending || pwm_update) && !load_c;
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared timebase plus per-channel shadowed
// compare/polarity registers driving registered outputs.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      pwm_mode,
   input  logic [WIDTH-1:0]          pwm_period,
   input  logic [CHANNELS*WIDTH-1:0] pwm_compare,
   input  logic [CHANNELS-1:0]       pwm_polarity,
   input  logic                      pwm_update,
   output logic [CHANNELS-1:0]       pwm_pulse,
   output logic                      pwm_done,
   output logic                      pwm_pending
);

   logic [WIDTH-1:0] count;
   logic             idle_c;
   logic             load_c;

   pwm_timebase #(
      .WIDTH(WIDTH)
   ) u_timebase (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .pwm_mode   (pwm_mode),
      .pwm_period (pwm_period),
      .pwm_update (pwm_update),
      .count      (count),
      .idle_c     (idle_c),
      .load_c     (load_c),
      .done       (pwm_done),
      .pending    (pwm_pending)
   );

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         localparam int unsigned LSB = ch_lsb(i, WIDTH);

         logic [WIDTH-1:0] cmp_q;
         logic             pol_q;
         logic             pulse_q;

         // Idle forces the inactive level, which is simply the polarity bit
         always_ff @(posedge clock) begin
            if (!reset) begin
               cmp_q   <= '0;
               pol_q   <= 1'b0;
               pulse_q <= 1'b0;
            end else begin
               if (load_c) begin
                  cmp_q <= pwm_compare[LSB +: WIDTH];
                  pol_q <= pwm_polarity[i];
               end
               pulse_q <= (!idle_c && (count < cmp_q)) ^ pol_q;
            end
         end

         assign pwm_pulse[i] = pulse_q;
      end
   endgenerate

endmodule
